serial_add_ctrl: RTL and testbench

//   Bit-serial adder sequencer. One 1-bit full-adder cell is reused for WIDTH

---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_add_ctrl_fa.sv | 25 ++
 rtl/serial_add_ctrl.sv | 97 +++++++++
 tb/tb_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the subtract path).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

  localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a controller and serial_add_ctrl.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub request bit).
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// 1-bit full adder cell built from two half adders; reused every RUN cycle.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.x(a),  .y(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first, WIDTH cycles.
// Optional feature macro: SERIAL_ADD_SUB_EN (sub=1 computes a + ~b + 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  // counter must hold WIDTH-1 without wrapping, even for WIDTH=1
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q, sum_nxt;
  logic             carry, cout_q;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  full_adder_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // new bit enters at the MSB; written this way so WIDTH=1 needs no slice
  always_comb begin
    sum_nxt            = sum_q >> 1;
    sum_nxt[WIDTH-1]   = fa_s;
  end

  // operand B and initial carry as loaded on accept
  always_comb begin
    b_ld = bus.b;
    c_ld = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
    if (bus.sub) begin
      b_ld = ~bus.b;
      c_ld = 1'b1;
    end
`endif
  end

  // FSM, shift registers, counter, carry flop and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_RUN;
            a_sh  <= bus.a;
            b_sh  <= b_ld;
            carry <= c_ld;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          sum_q <= sum_nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state  <= ST_DONE;
            cout_q <= fa_co;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
// Sub-path vectors are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   bc8 = 0, bc1 = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // monitor for the WIDTH=8 instance
  always @(negedge clk) begin
    if (rst) bc8 = 0;
    else begin
      if (bus8.busy) bc8++;
      if (bus8.done) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL done8_unexpected act=1 req=0 t=%0t", $time);
        end else begin
          e8 = q8.pop_front();
          chk("sum8", 32'(bus8.sum), 32'(e8.sum));
          chk("cout8", 32'(bus8.cout), 32'(e8.cout));
          chk("lat8", cyc, e8.cyc);
          chk("busy8", bc8, 8);
        end
        bc8 = 0;
      end
    end
  end

  // monitor for the WIDTH=1 instance
  always @(negedge clk) begin
    if (rst) bc1 = 0;
    else begin
      if (bus1.busy) bc1++;
      if (bus1.done) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL done1_unexpected act=1 req=0 t=%0t", $time);
        end else begin
          e1 = q1.pop_front();
          chk("sum1", 32'(bus1.sum), 32'(e1.sum[0]));
          chk("cout1", 32'(bus1.cout), 32'(e1.cout));
          chk("lat1", cyc, e1.cyc);
          chk("busy1", bc1, 1);
        end
        bc1 = 0;
      end
    end
  end

  // one-cycle start pulse on the 8-bit instance with expected result queued
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] es, input logic ec);
    exp_t e;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = sub;
`else
    if (sub) $display("note: sub vector issued without subtract build");
`endif
    e.sum = es; e.cout = ec; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic cin,
                        input logic es, input logic ec);
    exp_t e;
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.start = 1'b1;
    e.sum = {7'd0, es}; e.cout = ec; e.cyc = cyc + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit stable;
    int n;
    rst = 1'b1;
    bus8.start = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0;
    bus1.start = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = 0; bus1.sub = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus8.busy), 0);
    chk("rst_done", 32'(bus8.done), 0);
    chk("rst_sum", 32'(bus8.sum), 0);
    chk("rst_cout", 32'(bus8.cout), 0);
    @(negedge clk);
    rst = 1'b0;

    // a completed op gives sum/cout something nonzero to clear
    issue8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    repeat (10) @(negedge clk);

    // reset mid-RUN: operation started without a queued expectation
    @(negedge clk);
    bus8.a = 8'h5A; bus8.b = 8'h33; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus8.busy), 0);
    chk("arst_done", 32'(bus8.done), 0);
    chk("arst_sum", 32'(bus8.sum), 0);
    chk("arst_cout", 32'(bus8.cout), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // directed additions
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    issue8(8'h5A, 8'h33, 1'b1, 1'b0, 8'h8E, 1'b0);
    repeat (10) @(negedge clk);
    issue8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
    repeat (10) @(negedge clk);
    issue8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    issue8(8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1);
    repeat (10) @(negedge clk);

    // start during RUN cycle 3 must be ignored
    issue8(8'h21, 8'h43, 1'b0, 1'b0, 8'h64, 1'b0);
    @(negedge clk); @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (14) @(negedge clk);

    // start held high: three back-to-back ops, 10 cycles apart
    @(negedge clk);
    n = cyc;
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e8.sum = 8'h00; e8.cout = 1'b1; e8.cyc = n + 1 + 8 + 10 * k;
      q8.push_back(e8);
    end
    stable = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (cyc >= n + 9 && bus8.sum !== 8'h00) stable = 1'b0;
    end
    bus8.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus8.sum !== 8'h00) stable = 1'b0;
    end
    chk("held_sum_stable", 32'(stable), 1);

`ifdef SERIAL_ADD_SUB_EN
    issue8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    repeat (10) @(negedge clk);
    issue8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
    repeat (10) @(negedge clk);
    issue8(8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    issue8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
    repeat (10) @(negedge clk);
`endif

    // WIDTH=1 instance
    issue1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    issue1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    issue1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (12) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
